tl_a_channel_arbiter: RTL

- Round-robin arbiter sharing one TileLink A channel among N requesters, e.g. core ports feeding one TL link observed by the TL monitor.
- Burst-aware: once the first beat of a multi-beat data message (Put/Atomic) is granted, the grant is held until the last beat.
- Prefixes the winner's index onto the source ID so the D-channel demux can route responses.
- Single clock domain; sits directly upstream of the monitored link.

---
 rtl/tl_a_channel_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/tl_a_channel_arbiter.sv
// +--------------------------------------------------------------------------+
// | tl_a_channel_arbiter: burst-aware round-robin arbiter for a TileLink A     |
// | channel; optional checks enabled by TL_ARB_PROTOCOL_CHECK_EN.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tl_a_channel_arbiter #(
  parameter  int N_REQ      = 2,
  parameter  int ADDR_W     = 43,
  parameter  int DATA_BYTES = 8,
  parameter  int SRC_W      = 4,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_REQ-1:0]              in_valid,
  output logic [N_REQ-1:0]              in_ready,
  input  logic [3*N_REQ-1:0]            in_opcode,
  input  logic [3*N_REQ-1:0]            in_param,
  input  logic [4*N_REQ-1:0]            in_size,
  input  logic [SRC_W*N_REQ-1:0]        in_source,
  input  logic [ADDR_W*N_REQ-1:0]       in_address,
  input  logic [DATA_BYTES*N_REQ-1:0]   in_mask,
  input  logic [8*DATA_BYTES*N_REQ-1:0] in_data,
  input  logic [N_REQ-1:0]              in_corrupt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0]                    out_opcode,
  output logic [2:0]                    out_param,
  output logic [3:0]                    out_size,
  output logic [SRC_W+IDX_W-1:0]        out_source,
  output logic [ADDR_W-1:0]             out_address,
  output logic [DATA_BYTES-1:0]         out_mask,
  output logic [8*DATA_BYTES-1:0]       out_data,
  output logic                          out_corrupt,
  output logic                          busy
);

  localparam logic [3:0]       c_LOG_DB = 4'($clog2(DATA_BYTES));
  localparam logic [IDX_W-1:0] c_LAST   = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   c_N_EXT  = (IDX_W + 1)'(N_REQ);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_beat_cnt, w_beat_cnt_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0] r_grant_q, w_grant_q_nxt;

  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_scan_idx;
  logic             w_any_valid;
  logic [IDX_W-1:0] w_win;
  logic             w_ready_en;
  logic             w_fire;
  logic [SRC_W-1:0] w_src;
  logic             w_multi;
  logic [3:0]       w_shift;
  logic [7:0]       w_beats_m1;

  // Rotate the valids so offset 0 is rr_ptr; the lowest set offset wins.
  always_comb begin
    w_rot       = N_REQ'({in_valid, in_valid} >> r_rr_ptr);
    w_any_valid = |in_valid;
    w_off       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= c_N_EXT) w_scan_idx = IDX_W'(w_sum - c_N_EXT);
    else                  w_scan_idx = IDX_W'(w_sum);
  end

  always_comb begin
    w_win      = w_scan_idx;
    out_valid  = w_any_valid;
    w_ready_en = w_any_valid;
    if (r_state == S_BURST) begin
      w_win      = r_grant_q;
      out_valid  = in_valid[r_grant_q];
      w_ready_en = 1'b1;
    end
    in_ready = '0;
    if (w_ready_en) in_ready[w_win] = out_ready;
    w_fire = out_valid & out_ready;
  end

  always_comb begin
    out_opcode  = '0;
    out_param   = '0;
    out_size    = '0;
    w_src       = '0;
    out_address = '0;
    out_mask    = '0;
    out_data    = '0;
    out_corrupt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IDX_W'(i)) begin
        out_opcode  = in_opcode[3*i +: 3];
        out_param   = in_param[3*i +: 3];
        out_size    = in_size[4*i +: 4];
        w_src       = in_source[SRC_W*i +: SRC_W];
        out_address = in_address[ADDR_W*i +: ADDR_W];
        out_mask    = in_mask[DATA_BYTES*i +: DATA_BYTES];
        out_data    = in_data[8*DATA_BYTES*i +: 8*DATA_BYTES];
        out_corrupt = in_corrupt[i];
      end
    end
    out_source = {w_win, w_src};
  end

  // Opcodes 0..3 carry data; beat count - 1 = 2^(size - log2 bytes) - 1.
  always_comb begin
    w_multi    = ~out_opcode[2] && (out_size > c_LOG_DB);
    w_shift    = out_size - c_LOG_DB;
    w_beats_m1 = 8'((9'd1 << w_shift) - 9'd1);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_q_nxt  = r_grant_q;
    if (w_fire) begin
      if (r_state == S_IDLE) begin
        w_rr_ptr_nxt = (w_win == c_LAST) ? '0 : w_win + IDX_W'(1);
        if (w_multi) begin
          w_state_nxt    = S_BURST;
          w_grant_q_nxt  = w_win;
          w_beat_cnt_nxt = w_beats_m1;
        end
      end else begin
        w_beat_cnt_nxt = r_beat_cnt - 8'd1;
        if (r_beat_cnt == 8'd1) w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
      r_grant_q  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_q  <= w_grant_q_nxt;
    end
  end

  assign busy = (r_state == S_BURST);

`ifdef TL_ARB_PROTOCOL_CHECK_EN
`ifndef SYNTHESIS
  logic [2:0]        r_chk_op, r_chk_param;
  logic [3:0]        r_chk_size;
  logic [SRC_W-1:0]  r_chk_src;
  logic [ADDR_W-1:0] r_chk_addr;
  logic              r_prev_valid, r_prev_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_chk_op     <= '0;
      r_chk_param  <= '0;
      r_chk_size   <= '0;
      r_chk_src    <= '0;
      r_chk_addr   <= '0;
      r_prev_valid <= 1'b0;
      r_prev_ready <= 1'b0;
    end else begin
      if (r_state == S_BURST && out_valid &&
          {out_opcode, out_param, out_size, w_src, out_address} !=
          {r_chk_op, r_chk_param, r_chk_size, r_chk_src, r_chk_addr}) begin
        $display("tl_a_channel_arbiter: header changed mid-burst on requester %0d", r_grant_q);
        $fatal(1, "tl_a_channel_arbiter: burst header changed");
      end
      if (r_prev_valid && !r_prev_ready && !out_valid)
        $fatal(1, "tl_a_channel_arbiter: out_valid withdrawn without a fire");
      if (r_state == S_IDLE && w_fire && !out_opcode[2] && out_size > 4'd11)
        $fatal(1, "tl_a_channel_arbiter: data message size %0d too large", out_size);
      if (r_state == S_IDLE && w_fire) begin
        r_chk_op    <= out_opcode;
        r_chk_param <= out_param;
        r_chk_size  <= out_size;
        r_chk_src   <= w_src;
        r_chk_addr  <= out_address;
      end
      r_prev_valid <= out_valid;
      r_prev_ready <= out_ready;
    end
  end
`endif
`else
  // Checks compiled out: no extra state.
`endif

endmodule

`default_nettype wire
